fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the byte address into the asynchronous-read instruction memory. It captures the returned word into an IF output register with a valid/ready handshake toward the decoder. It also handles branch/jump redirects, and halts on an out-of-range or misaligned PC.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_reg.sv | 44 ++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_state_t : fetch sequencer states
//   fault_t       : halt cause reported on fetch_unit.fault
//   INSTR_BYTES   : PC increment per sequential fetch
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_RANGE    = 2'd1,
        FAULT_MISALIGN = 2'd2
    } fault_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_reg.sv
// IF output register: holds one fetched instruction and its addresses
// toward the decoder.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture instr_in/pc_in/pc_plus4_in and mark valid
//   flush         : drop the held instruction (wins over load)
//   consume       : consumer took the held instruction this cycle
//   instr_in, pc_in, pc_plus4_in : values to capture on load
//   valid, instr, pc, pc_plus4   : held contents
module fetch_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        consume,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= 32'd0;
            pc       <= 32'd0;
            pc_plus4 <= 32'd0;
        end else if (flush) begin
            // Only the valid bit is cleared; stale data is harmless.
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_in;
            pc       <= pc_in;
            pc_plus4 <= pc_plus4_in;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a zero-wait instruction
// memory, and hands words to the decoder over a valid/ready handshake.
// Stops permanently (until reset) on an out-of-range PC or misaligned
// redirect target.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   RUN    | normal sequential fetch, redirects honoured
//   DRAIN  | fault seen; no new loads, deliver the held word if any
//   HALTED | stopped; redirect and fetch_ready ignored until rst
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   instr_address / instruction_in    : instruction memory read port
//   redirect_valid / redirect_target  : branch/jump redirect
//   fetch_valid / fetch_ready         : handshake toward decoder
//   fetch_instr, fetch_pc, fetch_pc_plus4 : held instruction and addresses
//   halted, fault                     : stop status and cause
//   fetch_count                       : accepted instruction count (wraps)
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] reset_vector = 32'h0000_0000,
    parameter int unsigned mem_size     = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_address,
    input  logic [31:0] instruction_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_d;
    fault_t       fault_q, fault_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  pc_next_seq;
    logic         pc_in_range;
    logic         misaligned;
    logic         load, flush, consume;

    assign pc_next_seq = pc + INSTR_BYTES;
    assign pc_in_range = ({2'b00, pc[31:2]} < mem_size);
    assign misaligned  = (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= reset_vector;
            fault_q     <= FAULT_NONE;
            fetch_count <= 32'd0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            fault_q <= fault_d;
            if (consume) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        fault_d = fault_q;
        flush   = 1'b0;
        load    = 1'b0;
        consume = fetch_valid & fetch_ready;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (misaligned) begin
                        state_d = DRAIN;
                        fault_d = FAULT_MISALIGN;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!pc_in_range) begin
                    state_d = DRAIN;
                    fault_d = FAULT_RANGE;
                end else if (!fetch_valid || fetch_ready) begin
                    load = 1'b1;
                    pc_d = pc_next_seq;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (!misaligned) begin
                        pc_d = redirect_target;
                    end
                end
                // Halt once the output register is (or is about to be) empty.
                if (flush || consume || !fetch_valid) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                consume = 1'b0;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    fetch_reg u_fetch_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .consume     (consume),
        .instr_in    (instruction_in),
        .pc_in       (pc),
        .pc_plus4_in (pc_next_seq),
        .valid       (fetch_valid),
        .instr       (fetch_instr),
        .pc          (fetch_pc),
        .pc_plus4    (fetch_pc_plus4)
    );

    assign instr_address = pc;
    assign halted        = (state == HALTED);
    assign fault         = fault_q;

endmodule
